// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store engine between the control FSM and a
// single-word memory port with a valid/ready handshake.
//
// Ports:
//   clk, reset                 sole clock, synchronous active-high reset
//   req_valid/req_ready        request handshake from control FSM
//   req_store, req_funct3      access kind (RV32I funct3 width/sign)
//   req_addr, req_wdata        byte address and right-aligned store data
//   mem_valid/mem_ready        memory handshake (rdata valid with ready)
//   mem_addr, mem_we,
//   mem_wstrb, mem_wdata       word address, write enable, lanes, data
//   mem_rdata                  raw memory word
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_fault     aligned/extended load result, reject flag
//
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned H/HU/W
// accesses; otherwise they are forced to natural alignment.

module load_store_unit #(
    parameter int MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [MEM_ADDR_W-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  illegal;
    logic                  bad_kind;
    logic                  misalign;
    logic [1:0]            eff_off;
    logic [3:0]            wstrb_c;
    logic [31:0]           wdata_c;

    logic                  op_store;
    logic [2:0]            op_funct3;
    logic [1:0]            op_off;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           wdata_q;
    logic                  fault_q;
    logic [31:0]           rdata_q;

    logic [31:0]           shifted;
    logic [31:0]           load_data;

    assign accept = req_valid && (state == IDLE);

    // Request decode: legality, effective lane offset, store lanes/data.
    always_comb begin
        bad_kind = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: bad_kind = 1'b0;
            3'b100, 3'b101:         bad_kind = req_store;
            default:                bad_kind = 1'b1;
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        illegal = bad_kind || misalign;

        // Halves drop addr[0], words drop addr[1:0]; bytes keep both.
        eff_off = req_addr[1:0];
        case (req_funct3[1:0])
            2'b01:   eff_off = {req_addr[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase

        wstrb_c = 4'b0000;
        wdata_c = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << eff_off;
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << eff_off;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                wstrb_c = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
        if (!req_store) begin
            wstrb_c = 4'b0000;
        end
    end

    // Load alignment and extension from the captured access kind.
    always_comb begin
        shifted   = mem_rdata >> {op_off, 3'b000};
        load_data = shifted;
        case (op_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wstrb  = 4'b0000;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = illegal ? DONE : REQ;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_we    = op_store;
                mem_addr  = addr_q;
                mem_wstrb = wstrb_q;
                mem_wdata = wdata_q;
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_store  <= 1'b0;
            op_funct3 <= 3'b000;
            op_off    <= 2'b00;
            addr_q    <= '0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= 32'd0;
            fault_q   <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            if (accept) begin
                op_store  <= req_store;
                op_funct3 <= req_funct3;
                op_off    <= eff_off;
                addr_q    <= {req_addr[MEM_ADDR_W-1:2], 2'b00};
                wstrb_q   <= wstrb_c;
                wdata_q   <= wdata_c;
                fault_q   <= illegal;
                if (illegal) begin
                    rdata_q <= 32'd0;
                end
            end
            if ((state == REQ) && mem_ready) begin
                rdata_q <= op_store ? 32'd0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a byte-level reference model.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_resp = 32'd0;

    load_store_unit #(.MEM_ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: accesses as byte ranges in a little-endian word.
    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_fault(input bit st, input logic [2:0] f3,
                                    input logic [31:0] a);
        bit ok;
        ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
          || (!st && ((f3 == 3'd4) || (f3 == 3'd5)));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((int'(a[1:0]) % acc_size(f3)) != 0) ok = 1'b0;
`else
        if (a[31] === 1'bx) ok = 1'b0;
`endif
        return !ok;
    endfunction

    function automatic int first_byte(input logic [2:0] f3,
                                      input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        return off - (off % acc_size(f3));
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w,
                                             input logic [2:0] f3,
                                             input logic [31:0] a);
        int     sz;
        int     off;
        longint v;
        longint m;
        sz  = acc_size(f3);
        off = first_byte(f3, a);
        m   = (longint'(1) << (8 * sz)) - 1;
        v   = (longint'(w) >> (8 * off)) & m;
        if (!f3[2] && (sz < 4) && (v >= (m + 1) / 2)) v = v - (m + 1);
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_wstrb(input bit st,
                                             input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [3:0] s;
        int         off;
        s   = 4'b0000;
        off = first_byte(f3, a);
        for (int i = 0; i < 4; i++) begin
            if (st && (i >= off) && (i < off + acc_size(f3))) s[i] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3,
                                              input logic [31:0] w);
        logic [31:0] d;
        int          sz;
        sz = acc_size(f3);
        d  = 32'd0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = w[8*(i % sz) +: 8];
        return d;
    endfunction

    // One complete access; memory answers after waitc not-ready cycles.
    task automatic access(input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] rd, input int waitc);
        bit          f;
        logic [31:0] ea;
        f = is_fault(st, f3, a);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_hold_rdata", resp_rdata, last_resp);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = w;
        mem_ready  = 1'b0;
        tick();
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (f) begin
            check("flt_mem_valid", 32'(mem_valid), 32'd0);
            check("flt_resp_valid", 32'(resp_valid), 32'd1);
            check("flt_resp_fault", 32'(resp_fault), 32'd1);
            check("flt_rdata", resp_rdata, 32'd0);
            last_resp = 32'd0;
        end else begin
            for (int k = 0; k <= waitc; k++) begin
                check("req_mem_valid", 32'(mem_valid), 32'd1);
                check("req_ready_low", 32'(req_ready), 32'd0);
                check("req_no_resp", 32'(resp_valid), 32'd0);
                check("req_mem_addr", mem_addr, {a[31:2], 2'b00});
                check("req_mem_we", 32'(mem_we), 32'(st));
                check("req_wstrb", 32'(mem_wstrb), 32'(exp_wstrb(st, f3, a)));
                if (st) check("req_wdata", mem_wdata, exp_wdata(f3, w));
                mem_ready = (k == waitc);
                mem_rdata = (k == waitc) ? rd : $urandom;
                tick();
            end
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            ea = st ? 32'd0 : exp_load(rd, f3, a);
            check("done_resp_valid", 32'(resp_valid), 32'd1);
            check("done_resp_fault", 32'(resp_fault), 32'd0);
            check("done_rdata", resp_rdata, ea);
            check("done_mem_valid", 32'(mem_valid), 32'd0);
            last_resp = ea;
        end
        tick();
        check("post_resp_valid", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
        check("post_hold_rdata", resp_rdata, last_resp);
    endtask

    initial begin
        int acc;
        int rsp;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
        check("lw_result", resp_rdata, 32'hDEADBEEF);
        access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 0);
        check("lb_result", resp_rdata, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 1);
        check("lbu_result", resp_rdata, 32'h0000_0080);
        access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'd0, 3);
        access(1'b0, 3'b010, 32'h102, 32'd0, 32'hCAFEF00D, 0);
        access(1'b1, 3'b100, 32'h010, 32'h55, 32'd0, 0);
        access(1'b0, 3'b111, 32'h020, 32'd0, 32'd0, 0);

        // Reset while the memory handshake is pending.
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h300;
        tick();
        req_valid = 1'b0;
        check("mid_mem_valid", 32'(mem_valid), 32'd1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        reset = 1'b0;
        check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_resp", 32'(resp_valid), 32'd0);
        tick();
        mem_ready = 1'b0;
        check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        last_resp = 32'd0;

        // req_valid held high across two back-to-back transactions.
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h400;
        req_wdata  = 32'h0BAD_CAFE;
        mem_ready  = 1'b1;
        acc = 0;
        rsp = 0;
        for (int c = 0; c < 6; c++) begin
            if (req_valid && req_ready) acc++;
            tick();
            if (resp_valid) rsp++;
            if (c == 2) check("held_one_accept", 32'(acc), 32'd1);
            if (c == 2) check("held_idle_again", 32'(req_ready), 32'd1);
            if (c == 3) req_valid = 1'b0;
        end
        mem_ready = 1'b0;
        check("held_accepts", 32'(acc), 32'd2);
        check("held_resps", 32'(rsp), 32'd2);

        for (int n = 0; n < 60; n++) begin
            access(1'($urandom), 3'($urandom_range(7, 0)),
                   $urandom & 32'h0000_FFFF, $urandom, $urandom,
                   int'($urandom_range(3, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
